// File: rtl/funnel_pkg.sv
// Package: funnel_pkg
// Shared definitions for the funnel arbiter.
//   state_t     : arbiter FSM states (IDLE, ARM, XFER, DROP)
//   RED_1/RED_2 : the two legal reduct encodings in mode bits [1:0]
//   IDX_W       : width of requester indices (covers up to 8 requesters)
//   mode_legal  : true when a reduct field selects a supported reduction
package funnel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    XFER = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [1:0] RED_1 = 2'b01;
  localparam logic [1:0] RED_2 = 2'b10;
  localparam int         IDX_W = 3;

  function automatic logic mode_legal(input logic [1:0] reduct);
    return (reduct == RED_1) || (reduct == RED_2);
  endfunction

endpackage

// File: rtl/funnel_rr_pick.sv
// Module: funnel_rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// ptr and wrapping, returning the first active requester.
// Ports:
//   req        in   N_REQ   request vector
//   ptr        in   IDX_W   highest-priority index (always < N_REQ)
//   win_onehot out  N_REQ   one-hot winner, 0 when no request
//   win_idx    out  IDX_W   winner index, 0 when no request
//   win_valid  out  1       at least one request present
module funnel_rr_pick
  import funnel_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             win_valid
);

  int j;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    j          = 0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr < N_REQ, so a single subtraction is enough to wrap.
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!win_valid && req[j]) begin
        win_valid     = 1'b1;
        win_onehot[j] = 1'b1;
        win_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/funnel_arb.sv
// Module: funnel_arb
// Shares the funnel t_0 request port between N_REQ requesters. Grants
// round-robin, holds the grant for one complete reduction group and
// drives the winner's mode-table entry onto f_mode. f_mode only changes
// when leaving IDLE; a one-cycle ARM state lets the funnel sample the new
// mode before f_req rises. Requests whose mode has an illegal reduct are
// acknowledged and dropped with an err_drop pulse.
// Optional feature macro: FUNNEL_ARB_STATS_EN adds per-requester 16-bit
// saturating completed-group counters (stat_grp) and a synchronous clear
// (stat_clr).
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   r_req / r_ack      per-requester request (held) / acknowledge
//   cfg_req/id/mode    mode-table write; cfg_ack is always 1
//   f_req / f_ack      funnel t_0 request / last-beat acknowledge
//   f_mode             mode presented to the funnel
//   grant              one-hot current owner, 0 when idle
//   err_drop           1-cycle pulse when a request is dropped
module funnel_arb
  import funnel_pkg::*;
#(
  parameter int                N_REQ    = 4,
  parameter int                MODE_W   = 8,
  parameter logic [MODE_W-1:0] MODE_RST = MODE_W'(8'h02)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_REQ-1:0]  r_req,
  output logic [N_REQ-1:0]  r_ack,
  input  logic              cfg_req,
  input  logic [2:0]        cfg_id,
  input  logic [MODE_W-1:0] cfg_mode,
  output logic              cfg_ack,
  output logic              f_req,
  input  logic              f_ack,
  output logic [MODE_W-1:0] f_mode,
  output logic [N_REQ-1:0]  grant,
  output logic              err_drop
`ifdef FUNNEL_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] stat_grp,
  input  logic                stat_clr
`endif
);

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [IDX_W-1:0]  win_reg, win_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [MODE_W-1:0] f_mode_reg, f_mode_next;
  logic [MODE_W-1:0] mode_table [N_REQ];

  logic [N_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [MODE_W-1:0] pick_mode;
  logic              owner_req;
  logic [IDX_W-1:0]  ptr_after_win;

  funnel_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (r_req),
    .ptr        (rr_ptr_reg),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // Table is read with its current contents, so a write landing in the
  // same cycle as a grant of that id leaves the winner with the old mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_REQ; i++) mode_table[i] <= MODE_RST;
    end else if (cfg_req) begin
      // Ids >= N_REQ match no entry and are silently ignored.
      for (int i = 0; i < N_REQ; i++)
        if (cfg_id == IDX_W'(i)) mode_table[i] <= cfg_mode;
    end
  end

  always_comb begin
    pick_mode = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_onehot[i]) pick_mode = mode_table[i];
  end

  assign owner_req     = |(r_req & grant_reg);
  assign ptr_after_win = (win_reg == IDX_W'(N_REQ - 1)) ? '0 : win_reg + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      win_reg    <= '0;
      rr_ptr_reg <= '0;
      f_mode_reg <= MODE_RST;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      win_reg    <= win_next;
      rr_ptr_reg <= rr_ptr_next;
      f_mode_reg <= f_mode_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    win_next    = win_reg;
    rr_ptr_next = rr_ptr_reg;
    f_mode_next = f_mode_reg;
    f_req       = 1'b0;
    r_ack       = '0;
    err_drop    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next  = pick_onehot;
          win_next    = pick_idx;
          f_mode_next = pick_mode;
          state_next  = mode_legal(pick_mode[1:0]) ? ARM : DROP;
        end
      end
      ARM: begin
        state_next = XFER;
      end
      XFER: begin
        // A requester dropping r_req mid-group only lowers f_req; the
        // group is still in flight so ownership and mode stay put.
        f_req = owner_req;
        r_ack = grant_reg & {N_REQ{owner_req & f_ack}};
        if (owner_req && f_ack) begin
          grant_next  = '0;
          rr_ptr_next = ptr_after_win;
          state_next  = IDLE;
        end
      end
      DROP: begin
        r_ack       = grant_reg;
        err_drop    = 1'b1;
        grant_next  = '0;
        rr_ptr_next = ptr_after_win;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant   = grant_reg;
  assign f_mode  = f_mode_reg;
  assign cfg_ack = 1'b1;

`ifdef FUNNEL_ARB_STATS_EN
  logic grp_done;
  genvar gi;

  assign grp_done = (state_reg == XFER) && owner_req && f_ack;

  for (gi = 0; gi < N_REQ; gi++) begin : g_stat
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        cnt_reg <= '0;
      else if (stat_clr)
        cnt_reg <= '0;
      else if (grp_done && grant_reg[gi] && (cnt_reg != 16'hFFFF))
        cnt_reg <= cnt_reg + 16'd1;
    end
    assign stat_grp[gi*16 +: 16] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_funnel_arb.sv
// Testbench: tb_funnel_arb
// Directed checks of funnel_arb (N_REQ=4, MODE_W=8): reset values,
// latency, round-robin order, mode programming and table-write timing,
// illegal-mode drop, asynchronous reset mid-group and, when built with
// FUNNEL_ARB_STATS_EN, the completed-group counters.
module tb_funnel_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  r_req;
  logic [3:0]  r_ack;
  logic        cfg_req;
  logic [2:0]  cfg_id;
  logic [7:0]  cfg_mode;
  logic        cfg_ack;
  logic        f_req;
  logic        f_ack;
  logic [7:0]  f_mode;
  logic [3:0]  grant;
  logic        err_drop;
`ifdef FUNNEL_ARB_STATS_EN
  logic [63:0] stat_grp;
  logic        stat_clr;
`endif

  int errors = 0;
  int checks = 0;

  funnel_arb #(.N_REQ(4), .MODE_W(8), .MODE_RST(8'h02)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .r_req    (r_req),
    .r_ack    (r_ack),
    .cfg_req  (cfg_req),
    .cfg_id   (cfg_id),
    .cfg_mode (cfg_mode),
    .cfg_ack  (cfg_ack),
    .f_req    (f_req),
    .f_ack    (f_ack),
    .f_mode   (f_mode),
    .grant    (grant),
    .err_drop (err_drop)
`ifdef FUNNEL_ARB_STATS_EN
    ,
    .stat_grp (stat_grp),
    .stat_clr (stat_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] id, input logic [7:0] mode);
    cfg_req  = 1'b1;
    cfg_id   = id;
    cfg_mode = mode;
    tick();
    cfg_req  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    r_req   = '0;
    f_ack   = 1'b0;
    cfg_req = 1'b0;
`ifdef FUNNEL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    reset_n = 1'b1;
  endtask

  // One complete group for a lone requester, starting from IDLE.
  task automatic run_group(input logic [3:0] req);
    r_req = req;
    tick();
    tick();
    f_ack = 1'b1;
    tick();
    r_req = '0;
    f_ack = 1'b0;
  endtask

  logic [3:0] exp_g;

  initial begin
    reset_n  = 1'b0;
    r_req    = '0;
    f_ack    = 1'b0;
    cfg_req  = 1'b0;
    cfg_id   = '0;
    cfg_mode = '0;
`ifdef FUNNEL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    tick();
    tick();
    // Reset values
    chk("rst_r_ack", r_ack, 4'b0);
    chk("rst_f_req", f_req, 1'b0);
    chk("rst_f_mode", f_mode, 8'h02);
    chk("rst_grant", grant, 4'b0);
    chk("rst_err_drop", err_drop, 1'b0);
    chk("rst_cfg_ack", cfg_ack, 1'b1);
    reset_n = 1'b1;

    // 1: single requester, latency 2, ack with f_ack
    r_req = 4'b0001;
    #1;
    chk("t1_idle_f_req", f_req, 1'b0);
    tick();
    chk("t1_arm_grant", grant, 4'b0001);
    chk("t1_arm_f_req", f_req, 1'b0);
    chk("t1_arm_f_mode", f_mode, 8'h02);
    tick();
    chk("t1_xfer_f_req", f_req, 1'b1);
    chk("t1_xfer_r_ack_pre", r_ack, 4'b0);
    f_ack = 1'b1;
    #1;
    chk("t1_xfer_r_ack", r_ack, 4'b0001);
    tick();
    r_req = '0;
    f_ack = 1'b0;
    #1;
    chk("t1_done_grant", grant, 4'b0);
    chk("t1_done_r_ack", r_ack, 4'b0);

    // 2: all requesting, round-robin 0,1,2,3,0 from a fresh pointer
    do_reset();
    r_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      tick();
      chk($sformatf("t2_arm_grant%0d", k), grant, exp_g);
      chk($sformatf("t2_arm_f_req%0d", k), f_req, 1'b0);
      tick();
      chk($sformatf("t2_xfer_f_req%0d", k), f_req, 1'b1);
      f_ack = 1'b1;
      #1;
      chk($sformatf("t2_r_ack%0d", k), r_ack, exp_g);
      tick();
      f_ack = 1'b0;
    end
    r_req = '0;
    tick();

    // 3: programmed mode, mid-group write and mid-group r_req drop
    cfg_write(3'd2, 8'h01);
    r_req = 4'b0100;
    tick();
    chk("t3_arm_grant", grant, 4'b0100);
    chk("t3_arm_f_mode", f_mode, 8'h01);
    cfg_req  = 1'b1;
    cfg_id   = 3'd2;
    cfg_mode = 8'h02;
    tick();
    cfg_req = 1'b0;
    chk("t3_xfer_f_mode", f_mode, 8'h01);
    chk("t3_xfer_f_req", f_req, 1'b1);
    r_req = 4'b0000;
    #1;
    chk("t3_drop_req_f_req", f_req, 1'b0);
    tick();
    chk("t3_hold_grant", grant, 4'b0100);
    chk("t3_hold_f_mode", f_mode, 8'h01);
    r_req = 4'b0100;
    f_ack = 1'b1;
    #1;
    chk("t3_r_ack", r_ack, 4'b0100);
    tick();
    r_req = '0;
    f_ack = 1'b0;
    #1;
    chk("t3_done_grant", grant, 4'b0);
    r_req = 4'b0100;
    tick();
    chk("t3_new_mode", f_mode, 8'h02);
    tick();
    f_ack = 1'b1;
    tick();
    r_req = '0;
    f_ack = 1'b0;
    // Out-of-range id must not alias onto id 1
    cfg_write(3'd5, 8'h00);
    r_req = 4'b0010;
    tick();
    chk("t3_oob_err_drop", err_drop, 1'b0);
    chk("t3_oob_f_mode", f_mode, 8'h02);
    tick();
    f_ack = 1'b1;
    tick();
    r_req = '0;
    f_ack = 1'b0;

    // 4: illegal mode -> DROP
    cfg_write(3'd1, 8'h00);
    r_req = 4'b0010;
    tick();
    chk("t4_drop_grant", grant, 4'b0010);
    chk("t4_err_drop", err_drop, 1'b1);
    chk("t4_r_ack", r_ack, 4'b0010);
    chk("t4_f_req", f_req, 1'b0);
    chk("t4_f_mode", f_mode, 8'h00);
    r_req = '0;
    tick();
    chk("t4_after_err_drop", err_drop, 1'b0);
    chk("t4_after_r_ack", r_ack, 4'b0);
    chk("t4_after_grant", grant, 4'b0);
    // Same-cycle write and grant: winner sees the old (illegal) mode
    r_req    = 4'b0010;
    cfg_req  = 1'b1;
    cfg_id   = 3'd1;
    cfg_mode = 8'h01;
    tick();
    cfg_req = 1'b0;
    chk("t4_wr_grant_err_drop", err_drop, 1'b1);
    chk("t4_wr_grant_f_mode", f_mode, 8'h00);
    r_req = '0;
    tick();
    r_req = 4'b0010;
    tick();
    chk("t4_new_mode_err_drop", err_drop, 1'b0);
    chk("t4_new_mode_f_mode", f_mode, 8'h01);
    tick();
    f_ack = 1'b1;
    tick();
    r_req = '0;
    f_ack = 1'b0;

    // 5: reset mid-XFER
    r_req = 4'b1000;
    tick();
    tick();
    chk("t5_xfer_f_req", f_req, 1'b1);
    chk("t5_xfer_grant", grant, 4'b1000);
    reset_n = 1'b0;
    f_ack   = 1'b1;
    #1;
    chk("t5_rst_f_req", f_req, 1'b0);
    chk("t5_rst_grant", grant, 4'b0);
    chk("t5_rst_r_ack", r_ack, 4'b0);
    chk("t5_rst_f_mode", f_mode, 8'h02);
    f_ack = 1'b0;
    r_req = 4'b1001;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t5_regrant", grant, 4'b0001);
    tick();
    f_ack = 1'b1;
    tick();
    r_req = '0;
    f_ack = 1'b0;

`ifdef FUNNEL_ARB_STATS_EN
    // 6: completed-group counters
    do_reset();
    chk("t6_stat_rst", stat_grp, 32'h0);
    run_group(4'b0001);
    run_group(4'b0001);
    run_group(4'b0001);
    cfg_write(3'd0, 8'h00);
    r_req = 4'b0001;
    tick();
    r_req = '0;
    tick();
    chk("t6_stat_cnt", stat_grp[15:0], 16'd3);
    chk("t6_stat_others", stat_grp[63:16], 48'h0);
    cfg_write(3'd0, 8'h02);
    r_req = 4'b0001;
    tick();
    tick();
    f_ack    = 1'b1;
    stat_clr = 1'b1;
    tick();
    r_req    = '0;
    f_ack    = 1'b0;
    stat_clr = 1'b0;
    chk("t6_stat_clr", stat_grp[15:0], 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
